// File: rtl/rv_skid_buffer_pkg.sv
// Shared types and constants for the ready/valid skid buffer and its checker.
package rv_skid_buffer_pkg;

    localparam int DEFAULT_DATA_W = 32;

    // Encoding doubles as the occupancy count, so 3 is never reachable.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/rv_skid_buffer_if.sv
// Ready/valid stream bundle: upstream and downstream handshakes, flush and status.
interface rv_skid_buffer_if
    import rv_skid_buffer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [1:0]        count;
    logic              proto_err;

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, count, proto_err
    );

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, count, proto_err
    );
endinterface

// File: rtl/rv_stability_chk.sv
// Sticky detector for a ready/valid source that withdraws or changes a stalled payload.
module rv_stability_chk
    import rv_skid_buffer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    output logic              err
);
    logic              stalled;
    logic [DATA_W-1:0] held;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stalled <= 1'b0;
            held    <= '0;
            err     <= 1'b0;
        end else begin
            stalled <= valid & ~ready;
            held    <= data;
            if (stalled && (!valid || data != held)) begin
                err <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/rv_skid_buffer.sv
// Two-entry ready/valid skid buffer; in_ready depends only on state, never on out_ready.
module rv_skid_buffer
    import rv_skid_buffer_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    rv_skid_buffer_if.slave bus
);
    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              accept_in;
    logic              accept_out;

    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_data  = main_q;
    assign bus.count     = state;

    assign accept_in  = bus.in_valid  & bus.in_ready;
    assign accept_out = bus.out_valid & bus.out_ready;

    // NOTE: storage registers are reset too, because out_data must read 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (bus.flush) begin
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept_in) begin
                        main_q <= bus.in_data;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    case ({accept_in, accept_out})
                        2'b10: begin
                            skid_q <= bus.in_data;
                            state  <= FULL;
                        end
                        2'b01:   state  <= EMPTY;
                        2'b11:   main_q <= bus.in_data;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (accept_out) begin
                        main_q <= skid_q;
                        state  <= BUSY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    rv_stability_chk #(
        .DATA_W (DATA_W)
    ) u_stability_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (bus.in_valid),
        .ready (bus.in_ready),
        .data  (bus.in_data),
        .err   (bus.proto_err)
    );
endmodule

// File: doc/rv_skid_buffer.md
RV_SKID_BUFFER -- requirements
Module: rv_skid_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width in bits.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port in_valid  input  1  upstream payload valid.
REQ-005 The block SHALL have port in_ready  output  1  buffer can accept; driven from state flops only.
REQ-006 The block SHALL have port in_data  input  DATA_W  upstream payload.
REQ-007 The block SHALL have port out_valid  output  1  downstream payload valid.
REQ-008 The block SHALL have port out_ready  input  1  downstream can accept.
REQ-009 The block SHALL have port out_data  output  DATA_W  downstream payload, driven from the main register.
REQ-010 The block SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-011 The block SHALL have port count  output  2  entries held (0..2).
REQ-012 The block SHALL have port proto_err  output  1  sticky upstream stability violation flag.

Function
REQ-013 The block SHALL define accept_in = in_valid & in_ready and accept_out = out_valid & out_ready.
REQ-014 The block SHALL hold two storage registers: main (drives out_data) and skid (overflow entry).
REQ-015 The block SHALL implement states EMPTY (count 0), BUSY (count 1), FULL (count 2).
REQ-016 The block SHALL drive out_valid = (state != EMPTY) and in_ready = (state != FULL), with no combinational path from out_ready to in_ready.
REQ-017 EMPTY with accept_in SHALL load main <= in_data and go to BUSY.
REQ-018 BUSY with accept_in and no accept_out SHALL load skid <= in_data and go to FULL.
REQ-019 BUSY with accept_out and no accept_in SHALL go to EMPTY.
REQ-020 BUSY with accept_in and accept_out in the same cycle SHALL load main <= in_data and stay in BUSY.
REQ-021 FULL with accept_out SHALL load main <= skid and go to BUSY (in_ready low, so no input is accepted in FULL).
REQ-022 With no handshake in a cycle, state and storage SHALL hold.
REQ-023 Payloads SHALL leave in strict acceptance order, none lost or duplicated.
REQ-024 Minimum latency from accept_in to out_valid with that payload SHALL be 1 cycle.
REQ-025 Sustained throughput SHALL be 1 payload/cycle while out_ready stays high.
REQ-026 count SHALL equal the state encoding 0/1/2 and SHALL never read 3.
REQ-027 flush high SHALL set the state to EMPTY on the next edge, override any handshake that cycle, and discard held entries; out_valid SHALL be low the following cycle.
REQ-028 proto_err SHALL set when, in the previous cycle, in_valid was high and in_ready low, and in the current cycle in_valid is low or in_data differs.
REQ-029 proto_err SHALL stay set until reset and SHALL NOT be cleared by flush.

Reset
REQ-030 rst_n low at a clock edge SHALL force state EMPTY, count 0, out_valid 0, in_ready 1, proto_err 0, and clear main, skid and out_data to 0.
REQ-031 Reset SHALL take priority over flush and handshakes; reset mid-transfer SHALL drop all held payloads.
REQ-032 In the first cycle after rst_n rises, in_ready SHALL be 1.

Structure
REQ-033 The shared package SHALL hold the state enum (EMPTY=0, BUSY=1, FULL=2) and the default data width constant of 32.
REQ-034 The proto_err stability checker SHALL be a separate sub-module rv_stability_chk, reusable on any ready/valid input.
REQ-035 Data storage and the FSM SHALL remain in rv_skid_buffer.

Verification
REQ-036 Stream bench: out_ready=1, send 0x1..0x8 back-to-back -> out_data 0x1..0x8 in order, one per cycle, first one cycle after its accept.
REQ-037 Stall bench: send 0xA, 0xB with out_ready=0 -> count=2, in_ready=0; raise out_ready -> 0xA then 0xB out, and in_ready high the cycle after 0xA leaves.
REQ-038 Simultaneous bench: in BUSY holding 0xC, accept 0xD while 0xC drains -> count stays 1 and out_data=0xD next cycle.
REQ-039 Flush bench: in FULL, assert flush -> next cycle count=0, out_valid=0, in_ready=1; 0x5 sent afterward emerges alone.
REQ-040 Protocol bench: in FULL, drop in_valid while in_ready=0 -> proto_err=1, still 1 after flush, 0 after rst_n pulse.
REQ-041 Reset bench: assert rst_n=0 while FULL -> next cycle out_valid=0, count=0, out_data=0, in_ready=1.
